// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller for a small accumulator ALU datapath.
// It accepts one instruction at a time, runs a data-memory read/write
// handshake when the opcode needs one, drives the ALU operand/op selects
// and the accumulator write, then pulses the program-counter increment.
// All outputs are registered and depend only on the state and the latched
// opcode, so no input reaches an output combinationally.
//
// Optional feature: define MEM_TIMEOUT_EN to give up on a memory transfer
// after TIMEOUT_CYCLES cycles without MemAck. The abandoned instruction
// pulses Fault for one cycle and retires without WrAcc or PcInc. Without
// the macro the controller waits in MEM indefinitely and Fault is tied low.
module alu_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       InstrValid,
  input  logic [3:0] Opcode,
  output logic       InstrReady,
  output logic       MemRd,
  output logic       MemWr,
  input  logic       MemAck,
  output logic       SelB,
  output logic [1:0] AluOp,
  output logic       WrAcc,
  output logic       PcInc,
  output logic       Halted,
  output logic       Fault
);

  localparam logic [3:0] OP_HLT  = 4'd0;
  localparam logic [3:0] OP_STO  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;

  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_DONE,
    ST_HALTED
`ifdef MEM_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  // Registered control outputs, kept together so one assignment updates all.
  typedef struct packed {
    logic       ready;
    logic       rd;
    logic       wr;
    logic       selb;
    logic [1:0] aluop;
    logic       wracc;
    logic       pc;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{ready: 1'b1, default: '0};

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] op_q;
  logic [3:0] op_nxt;
  ctrl_t      ctrl_q;

  // Output values the controller must show while sitting in a given state.
  function automatic ctrl_t decode_outputs(input state_t st, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IDLE:   c.ready = 1'b1;
      ST_MEM: begin
        c.wr = (op == OP_STO);
        c.rd = (op != OP_STO);
      end
      ST_EXEC: begin
        c.wracc = 1'b1;
        c.selb  = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
        case (op)
          OP_ADD, OP_ADDI: c.aluop = ALU_ADD;
          OP_SUB, OP_SUBI: c.aluop = ALU_SUB;
          default:         c.aluop = ALU_PASS_B;
        endcase
      end
      ST_DONE:   c.pc     = 1'b1;
      ST_HALTED: c.halted = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       fault_q;

  // Last counted MEM cycle; MemAck on this cycle still wins over the timeout.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Count cycles spent in MEM; held at zero elsewhere so every entry starts at zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q != ST_MEM) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`endif

  // Next-state and opcode-latch decision for the sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state_q;
    op_nxt    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid) begin
          op_nxt    = Opcode;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op_q)
          OP_HLT:                          state_nxt = ST_HALTED;
          OP_LDI, OP_ADDI, OP_SUBI:        state_nxt = ST_EXEC;
          OP_STO, OP_LD, OP_ADD, OP_SUB:   state_nxt = ST_MEM;
          default:                         state_nxt = ST_DONE;
        endcase
      end
      ST_MEM: begin
        if (MemAck) begin
          state_nxt = (op_q == OP_STO) ? ST_DONE : ST_EXEC;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = ST_FAULT;
        end
`endif
      end
      ST_EXEC:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_HALTED: state_nxt = ST_HALTED;
`ifdef MEM_TIMEOUT_EN
      ST_FAULT:  state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, latched opcode and registered outputs advance together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ctrl_q  <= CTRL_RESET;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      ctrl_q  <= decode_outputs(state_nxt, op_nxt);
    end
  end

`ifdef MEM_TIMEOUT_EN
  // One-cycle Fault pulse while retiring an abandoned memory transfer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_nxt == ST_FAULT);
    end
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign InstrReady = ctrl_q.ready;
  assign MemRd      = ctrl_q.rd;
  assign MemWr      = ctrl_q.wr;
  assign SelB       = ctrl_q.selb;
  assign AluOp      = ctrl_q.aluop;
  assign WrAcc      = ctrl_q.wracc;
  assign PcInc      = ctrl_q.pc;
  assign Halted     = ctrl_q.halted;

endmodule
